// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounces the mode button and supplies the PWM stage with a
// duty value that only changes on period boundaries.
// Ports:
//   sys_clk, sys_rst_n : clock, async active-low reset
//   key_n              : raw bouncy push-button, active-low, async
//   period_start       : PWM counter-wrap pulse from the PWM stage
//   duty, duty_valid   : duty in clock cycles, one-cycle reload strobe
//   mode               : 0 OFF, 1 DIM, 2 FULL, 3 BREATH
//   key_pulse          : one-cycle pulse per accepted press
module pwm_duty_ctrl #(
  parameter logic [19:0] PWM_PERIOD      = 20'd10_000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [19:0] BREATH_STEP     = 20'd50,
  parameter logic [19:0] DIM_DUTY        = PWM_PERIOD >> 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        key_n,
  input  logic        period_start,
  output logic [19:0] duty,
  output logic        duty_valid,
  output logic [1:0]  mode,
  output logic        key_pulse
);

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_DIM    = 2'd1,
    M_FULL   = 2'd2,
    M_BREATH = 2'd3
  } mode_e;

  mode_e       mode_q, mode_d;
  logic        sync1_q, sync2_q;
  logic [19:0] cnt_q, cnt_d;
  logic        deb_q, deb_d;
  logic        kp_q, kp_d;
  logic [19:0] duty_q, duty_d;
  logic        dv_q, dv_d;
  logic [19:0] lvl_q, lvl_d;
  logic        up_q, up_d;
  logic [19:0] target;
  logic [20:0] sum;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      deb_q   <= 1'b1;
      kp_q    <= 1'b0;
      mode_q  <= M_OFF;
      duty_q  <= '0;
      dv_q    <= 1'b0;
      lvl_q   <= '0;
      up_q    <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      kp_q    <= kp_d;
      mode_q  <= mode_d;
      duty_q  <= duty_d;
      dv_q    <= dv_d;
      lvl_q   <= lvl_d;
      up_q    <= up_d;
    end
  end

  // Debounce: counter only runs while the synchronized key disagrees
  // with the accepted level; a press is the accepted 1->0 edge.
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    kp_d  = 1'b0;
    if (sync2_q != deb_q) begin
      if (cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        deb_d = sync2_q;
        kp_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 20'd1;
      end
    end
  end

  always_comb begin
    mode_d = mode_q;
    if (kp_q) begin
      unique case (mode_q)
        M_OFF:    mode_d = M_DIM;
        M_DIM:    mode_d = M_FULL;
        M_FULL:   mode_d = M_BREATH;
        M_BREATH: mode_d = M_OFF;
        default:  mode_d = M_OFF;
      endcase
    end
  end

  always_comb begin
    target = '0;
    unique case (mode_q)
      M_OFF:    target = '0;
      M_DIM:    target = DIM_DUTY;
      M_FULL:   target = PWM_PERIOD;
      M_BREATH: target = lvl_q;
      default:  target = '0;
    endcase
  end

  // Duty uses the mode held before the edge, so a coincident press
  // only affects the following period.
  always_comb begin
    duty_d = duty_q;
    dv_d   = period_start;
    if (period_start) duty_d = target;
  end

  // Breath level is advanced after being sampled for duty.
  always_comb begin
    lvl_d = lvl_q;
    up_d  = up_q;
    sum   = {1'b0, lvl_q} + {1'b0, BREATH_STEP};
    unique case (1'b1)
      kp_q && (mode_q == M_FULL): begin
        lvl_d = '0;
        up_d  = 1'b1;
      end
      period_start && (mode_q == M_BREATH) && up_q: begin
        if (sum >= {1'b0, PWM_PERIOD}) begin
          lvl_d = PWM_PERIOD;
          up_d  = 1'b0;
        end else begin
          lvl_d = sum[19:0];
        end
      end
      period_start && (mode_q == M_BREATH) && !up_q: begin
        if (lvl_q <= BREATH_STEP) begin
          lvl_d = '0;
          up_d  = 1'b1;
        end else begin
          lvl_d = lvl_q - BREATH_STEP;
        end
      end
      default: begin
        lvl_d = lvl_q;
        up_d  = up_q;
      end
    endcase
  end

  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign mode       = mode_q;
  assign key_pulse  = kp_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: randomized scoreboard bench for pwm_duty_ctrl.
// Stimulus pushes expected duty/mode; a negedge monitor pops and compares.
module tb_pwm_duty_ctrl;

  localparam logic [19:0] P   = 20'd100;
  localparam logic [19:0] D   = 20'd8;
  localparam logic [19:0] S   = 20'd30;
  localparam logic [19:0] DIM = 20'd25;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        key_n = 1'b1;
  logic        period_start = 1'b0;
  logic [19:0] duty;
  logic        duty_valid;
  logic [1:0]  mode;
  logic        key_pulse;

  int total = 0;
  int bad = 0;
  int m_mode = 0;
  int m_lvl = 0;
  bit m_up = 1'b1;
  int exp_duty[$];
  int exp_mode[$];
  int pulses = 0;
  int exp_pulses = 0;
  int last_duty = 0;
  bit pend = 1'b0;

  pwm_duty_ctrl #(
    .PWM_PERIOD(P),
    .DEBOUNCE_CYCLES(D),
    .BREATH_STEP(S),
    .DIM_DUTY(DIM)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n(key_n),
    .period_start(period_start),
    .duty(duty),
    .duty_valid(duty_valid),
    .mode(mode),
    .key_pulse(key_pulse)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  function automatic int target();
    case (m_mode)
      0: return 0;
      1: return int'(DIM);
      2: return int'(P);
      default: return m_lvl;
    endcase
  endfunction

  // Triangle wave between 0 and P, clamped at both ends.
  function automatic void breath_adv();
    int n;
    n = m_up ? m_lvl + int'(S) : m_lvl - int'(S);
    if (n >= int'(P)) begin
      n = int'(P);
      m_up = 1'b0;
    end else if (n <= 0) begin
      n = 0;
      m_up = 1'b1;
    end
    m_lvl = n;
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      last_duty = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        total++;
        if (exp_mode.size() == 0) begin
          bad++;
          $display("FAIL mode_unexpected: got %0d required none", mode);
        end else begin
          chk("mode", int'(mode), exp_mode.pop_front());
        end
      end
      if (key_pulse) begin
        pulses++;
        pend = 1'b1;
      end
      if (duty_valid) begin
        total++;
        if (exp_duty.size() == 0) begin
          bad++;
          $display("FAIL dv_unexpected: got duty %0d required no valid", duty);
        end else begin
          chk("duty", int'(duty), exp_duty.pop_front());
        end
        last_duty = int'(duty);
      end else begin
        chk("duty_hold", int'(duty), last_duty);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic ps(input int gap);
    repeat (gap - 1) tick();
    period_start = 1'b1;
    exp_duty.push_back(target());
    if (m_mode == 3) breath_adv();
    tick();
    period_start = 1'b0;
    chk("dv_latency", int'(duty_valid), 1);
  endtask

  task automatic press(input int nb, input bit with_ps);
    for (int b = 0; b < nb; b++) begin
      key_n = 1'b0;
      repeat ($urandom_range(1, 5)) tick();
      key_n = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
    end
    key_n = 1'b0;
    repeat (9) tick();
    chk("kp_early", int'(key_pulse), 0);
    tick();
    chk("kp_latency", int'(key_pulse), 1);
    if (with_ps) begin
      period_start = 1'b1;
      exp_duty.push_back(target());
      if (m_mode == 3) breath_adv();
    end
    exp_pulses++;
    m_mode = (m_mode + 1) % 4;
    if (m_mode == 3) begin
      m_lvl = 0;
      m_up = 1'b1;
    end
    exp_mode.push_back(m_mode);
    tick();
    period_start = 1'b0;
    if (with_ps) chk("dv_latency_sim", int'(duty_valid), 1);
    repeat ($urandom_range(2, 6)) tick();
    key_n = 1'b1;
    repeat (12) tick();
    chk("pulse_count", pulses, exp_pulses);
  endtask

  task automatic glitch();
    key_n = 1'b0;
    repeat ($urandom_range(1, 5)) tick();
    key_n = 1'b1;
    repeat (10) tick();
    chk("glitch_pulses", pulses, exp_pulses);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_duty", int'(duty), 0);
    chk("rst_dv", int'(duty_valid), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_kp", int'(key_pulse), 0);
    sys_rst_n = 1'b1;
    repeat (3) tick();

    // bouncy press: toggles every 3 cycles, then final fall
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (3) tick();
    end
    press(0, 1'b0);

    ps(100);
    ps(100);
    press(1, 1'b0);
    ps(100);
    press(2, 1'b0);
    for (int i = 0; i < 10; i++) ps(100);
    press(0, 1'b0);
    ps(100);

    // coincident press and period start while in DIM
    press(0, 1'b0);
    ps(100);
    press(0, 1'b1);
    ps(100);

    // reset mid-breath at level 60, direction up
    press(0, 1'b0);
    ps(100);
    ps(100);
    tick();
    sys_rst_n = 1'b0;
    period_start = 1'b1;
    #1;
    chk("mid_rst_duty", int'(duty), 0);
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_dv", int'(duty_valid), 0);
    repeat (3) tick();
    period_start = 1'b0;
    sys_rst_n = 1'b1;
    m_mode = 0;
    m_lvl = 0;
    m_up = 1'b1;
    tick();
    chk("post_rst_dv", int'(duty_valid), 0);
    ps(50);
    press(0, 1'b0);
    press(1, 1'b0);
    press(0, 1'b0);
    for (int i = 0; i < 3; i++) ps(100);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 4) ps(int'($urandom_range(2, 120)));
      else if (r < 8) press(int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      else glitch();
    end

    repeat (5) tick();
    chk("final_pulses", pulses, exp_pulses);
    chk("duty_queue_left", exp_duty.size(), 0);
    chk("mode_queue_left", exp_mode.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_ctrl.md
Name: pwm_duty_ctrl

Overview:
- Upstream control stage for the LED PWM generator. It debounces a user push-button and steps through four lighting modes: OFF, DIM, FULL and BREATH.
- It produces the duty value, counted in sys_clk cycles per PWM period, that the PWM stage compares against its period counter.
- Duty changes are applied only on the PWM stage's period-start pulse, so the LED never sees a truncated or glitched period.

Parameters:
- PWM_PERIOD, 20'd10_000, PWM period in sys_clk cycles; full-scale duty value.
- DEBOUNCE_CYCLES, 20'd1_000_000, cycles the synchronized key must stay stable to be accepted (20 ms at 50 MHz).
- BREATH_STEP, 20'd50, duty increment/decrement applied per PWM period in BREATH mode.
- DIM_DUTY, PWM_PERIOD/4, duty used in DIM mode.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset.
- key_n  in  1  raw push-button, active-low, asynchronous to sys_clk, bouncy.
- period_start  in  1  one-cycle pulse from the PWM stage on the cycle its counter wraps to 0.
- duty  out  20  current duty; the PWM stage drives the LED high while its counter < duty.
- duty_valid  out  1  one-cycle pulse on the cycle duty is reloaded.
- mode  out  2  current mode: 0 OFF, 1 DIM, 2 FULL, 3 BREATH.
- key_pulse  out  1  one-cycle pulse per accepted key press.

Behaviour:
- Reset: sys_rst_n is asynchronous, active-low; sys_clk is the only clock. All registers clear on reset: duty=0, duty_valid=0, mode=0, key_pulse=0, breath level=0, breath direction=up, debounce counter=0, debounced key=1, synchronizer flops=1. Reset asserted mid-operation returns the block to exactly this state; no pending press survives.
- Input sync: key_n passes through a 2-flop synchronizer before any use.
- Debounce:
  - The counter clears whenever the synchronized key equals the debounced key.
  - Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced key takes the synchronized value and the counter clears.
  - A 1→0 transition of the debounced key produces key_pulse for exactly one cycle. Release (0→1) produces no pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Mode FSM:
  - Advances one step on key_pulse at the same clock edge: OFF→DIM→FULL→BREATH→OFF.
  - Entering BREATH forces breath level=0 and direction=up.
- Target per mode: OFF=0, DIM=DIM_DUTY, FULL=PWM_PERIOD, BREATH=current breath level.
- Duty load:
  - On a cycle where period_start=1, duty is registered with the target computed from the mode value held before that edge.
  - duty_valid=1 on the following cycle only. Latency from period_start to new duty is 1 cycle.
  - If period_start and key_pulse coincide, the duty loaded at that edge uses the old mode; the new mode takes effect at the next period_start.
- Breath update: happens only in BREATH mode, on period_start, after the level has been sampled for duty.
  - Direction up: next = level+BREATH_STEP, computed 21 bits wide. If next ≥ PWM_PERIOD, level=PWM_PERIOD and direction flips to down.
  - Direction down: if level ≤ BREATH_STEP, level=0 and direction flips to up; else level -= BREATH_STEP.
  - Level never exceeds PWM_PERIOD and never underflows.
- Outputs are held between period_start pulses. A period_start arriving while the block is in reset is ignored.

Test Plan:
- Common bench parameters: PWM_PERIOD=100, DEBOUNCE_CYCLES=8, BREATH_STEP=30, DIM_DUTY=25. period_start is pulsed every 100 cycles unless stated otherwise.
- Bounce: toggle key_n every 3 cycles for 30 cycles, then hold low 20 cycles → exactly one key_pulse, 2+8 cycles after the final fall. mode goes 0→1. Release yields no pulse.
- DIM timing: mode=1, then period_start → duty=25 and duty_valid high exactly 1 cycle after period_start, low otherwise. duty holds 25 across the next 99 cycles.
- Breath profile: enter mode 3, then apply 10 period_starts → successive duty values 0,30,60,90,100,70,40,10,0,30.
- Mode wrap: four accepted presses from OFF → mode sequence 1,2,3,0. The next period_start after the return to OFF loads duty=0. In FULL, duty=100.
- Simultaneous: key_pulse and period_start on the same cycle while in DIM → that load gives duty=25 and mode becomes 2. The next period_start gives duty=100.
- Reset mid-breath: assert sys_rst_n=0 for 3 cycles at level 60 (direction up) → duty=0, mode=0, duty_valid=0 immediately. After release, the next period_start loads duty=0. Re-entering BREATH restarts the profile at 0.
